core_io_port: RTL and testbench

- Core-side endpoint of the engine↔core link. It receives the 16x32-bit data blocks that the engine's core_input/realign path broadcasts into one of two per-core input slots, selected by seq.
- It hands full slots to the SHA-256 round logic and serializes 8-word results back to engine memory on core_dout/core_dout_en/core_dout_seq.
- It drives core_ready, which engine process_bytes uses for dispatch.

---
 rtl/core_io_port_pkg.sv | 13 +
 rtl/core_io_dout_ser.sv | 74 +++++++
 rtl/core_io_port.sv | 168 ++++++++++++++++
 tb/tb_core_io_port.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_io_port_pkg.sv
// Shared constants and slot-state encoding for the core-side engine link endpoint.
package core_io_port_pkg;

  localparam int BLK_OP_MSB = 2;
  localparam int OUT_WORDS  = 8;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FULL  = 2'd1,
    SLOT_BUSY  = 2'd2
  } slot_state_e;

endpackage

// File: rtl/core_io_dout_ser.sv
// Result buffer and burst serializer: holds OUT_WORDS result words and streams
// them back to engine memory as one back-to-back burst tagged with the slot seq.
module core_io_dout_ser #(
  parameter int OUT_WORDS = core_io_port_pkg::OUT_WORDS,
  parameter int AW        = $clog2(OUT_WORDS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          res_wr_en,
  input  logic [AW-1:0] res_addr,
  input  logic [31:0]   res_din,
  input  logic          res_last,
  input  logic          blk_seq,
  output logic [31:0]   core_dout,
  output logic          core_dout_en,
  output logic          core_dout_seq,
  output logic          out_busy
);

  logic [31:0]   buf_q [OUT_WORDS];
  logic [31:0]   buf_d [OUT_WORDS];
  logic [AW-1:0] rem_q, rem_d;
  logic          en_q, en_d;
  logic [31:0]   dout_q, dout_d;
  logic          seq_q, seq_d;

  always_comb begin
    buf_d  = buf_q;
    rem_d  = rem_q;
    en_d   = en_q;
    dout_d = dout_q;
    seq_d  = seq_q;
    if (res_wr_en && !en_q) buf_d[res_addr] = res_din;
    if (en_q) begin
      if (rem_q == '0) begin
        en_d   = 1'b0;
        dout_d = '0;
      end else begin
        // rem_q counts words still to send after the one on the bus
        dout_d = buf_q[AW'(OUT_WORDS - int'(rem_q))];
        rem_d  = rem_q - AW'(1);
      end
    end else if (res_last) begin
      en_d   = 1'b1;
      dout_d = buf_d[0];
      rem_d  = AW'(OUT_WORDS - 1);
      seq_d  = blk_seq;
    end
  end

  always_ff @(posedge CLK) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem_q  <= '0;
      en_q   <= 1'b0;
      dout_q <= '0;
      seq_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      en_q   <= en_d;
      dout_q <= dout_d;
      seq_q  <= seq_d;
    end
  end

  assign core_dout     = dout_q;
  assign core_dout_en  = en_q;
  assign core_dout_seq = seq_q;
  assign out_busy      = en_q;

endmodule

// File: rtl/core_io_port.sv
// Core-side endpoint of the engine<->core link: two input slots, hand-off to the
// round logic, result serializer. Protocol checking is built only with CORE_IO_CHECK_EN.
//
// Per-slot state | meaning
// SLOT_EMPTY     | slot free, engine may fill it
// SLOT_FULL      | block complete, waiting for the round logic
// SLOT_BUSY      | block being processed by the round logic
module core_io_port
  import core_io_port_pkg::*;
#(
  parameter int BLK_OP_W  = BLK_OP_MSB + 1,
  parameter int OUT_WORDS = core_io_port_pkg::OUT_WORDS
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                wr_en,
  input  logic [31:0]         din,
  input  logic [3:0]          wr_addr,
  input  logic                seq,
  input  logic [BLK_OP_W-1:0] blk_op_in,
  input  logic                set_input_ready,
  output logic                ready,
  output logic                blk_start,
  output logic                blk_seq,
  output logic [BLK_OP_W-1:0] blk_op,
  input  logic [3:0]          comp_rd_addr,
  output logic [31:0]         comp_dout,
  input  logic                comp_done,
  input  logic                res_wr_en,
  input  logic [2:0]          res_addr,
  input  logic [31:0]         res_din,
  input  logic                res_last,
  output logic                out_busy,
  output logic [31:0]         core_dout,
  output logic                core_dout_en,
  output logic                core_dout_seq,
  output logic                err
);

  slot_state_e         state_q [2];
  slot_state_e         state_d [2];
  logic [BLK_OP_W-1:0] op_q [2];
  logic [BLK_OP_W-1:0] op_d [2];
  logic                wr_seq_exp_q, wr_seq_exp_d;
  logic                rd_seq_q, rd_seq_d;
  logic                ready_q, ready_d;
  logic                blk_start_q, blk_start_d;
  logic                blk_seq_q, blk_seq_d;
  logic [BLK_OP_W-1:0] blk_op_q, blk_op_d;
  logic [31:0]         comp_dout_q;
  logic [31:0]         mem_q [32];
  logic                any_busy;

  assign any_busy = (state_q[0] == SLOT_BUSY) || (state_q[1] == SLOT_BUSY);

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    wr_seq_exp_d = wr_seq_exp_q;
    rd_seq_d     = rd_seq_q;
    blk_start_d  = 1'b0;
    blk_seq_d    = blk_seq_q;
    blk_op_d     = blk_op_q;
    if (!any_busy && state_q[rd_seq_q] == SLOT_FULL) begin
      state_d[rd_seq_q] = SLOT_BUSY;
      blk_start_d       = 1'b1;
      blk_seq_d         = rd_seq_q;
      blk_op_d          = op_q[rd_seq_q];
    end
    if (comp_done && any_busy) begin
      state_d[blk_seq_q] = SLOT_EMPTY;
      rd_seq_d           = ~rd_seq_q;
    end
    if (set_input_ready) begin
      state_d[seq] = SLOT_FULL;
      op_d[seq]    = blk_op_in;
      wr_seq_exp_d = ~wr_seq_exp_q;
    end
    // looks at the post-update state so ready has no extra cycle of lag
    ready_d = (state_d[wr_seq_exp_d] == SLOT_EMPTY);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= '{default: SLOT_EMPTY};
      op_q         <= '{default: '0};
      wr_seq_exp_q <= 1'b0;
      rd_seq_q     <= 1'b0;
      ready_q      <= 1'b0;
      blk_start_q  <= 1'b0;
      blk_seq_q    <= 1'b0;
      blk_op_q     <= '0;
      comp_dout_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wr_seq_exp_q <= wr_seq_exp_d;
      rd_seq_q     <= rd_seq_d;
      ready_q      <= ready_d;
      blk_start_q  <= blk_start_d;
      blk_seq_q    <= blk_seq_d;
      blk_op_q     <= blk_op_d;
      comp_dout_q  <= mem_q[{blk_seq_q, comp_rd_addr}];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[{seq, wr_addr}] <= din;
  end

  assign ready     = ready_q;
  assign blk_start = blk_start_q;
  assign blk_seq   = blk_seq_q;
  assign blk_op    = blk_op_q;
  assign comp_dout = comp_dout_q;

  core_io_dout_ser #(
    .OUT_WORDS(OUT_WORDS),
    .AW       (3)
  ) u_dout_ser (
    .CLK          (CLK),
    .RST          (RST),
    .res_wr_en    (res_wr_en),
    .res_addr     (res_addr),
    .res_din      (res_din),
    .res_last     (res_last),
    .blk_seq      (blk_seq_q),
    .core_dout    (core_dout),
    .core_dout_en (core_dout_en),
    .core_dout_seq(core_dout_seq),
    .out_busy     (out_busy)
  );

`ifdef CORE_IO_CHECK_EN
  logic [15:0] mask_q [2];
  logic [15:0] mask_d [2];
  logic [15:0] mask_now;
  logic        err_q, err_d;

  always_comb begin
    mask_d = mask_q;
    if (wr_en) mask_d[seq] = mask_q[seq] | (16'd1 << wr_addr);
    // a word written alongside set_input_ready counts toward completeness
    mask_now = mask_d[seq];
    if (set_input_ready) mask_d[seq] = '0;
    err_d = err_q;
    if (wr_en && state_q[seq] != SLOT_EMPTY) err_d = 1'b1;
    if (set_input_ready && (seq != wr_seq_exp_q || mask_now != 16'hFFFF)) err_d = 1'b1;
    if (comp_done && !any_busy) err_d = 1'b1;
    if ((res_last || res_wr_en) && out_busy) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q <= '{default: '0};
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_core_io_port.sv
// Directed-sequence bench with randomized data, checked against a slot-ring model.
module tb_core_io_port;

  localparam int OPW = core_io_port_pkg::BLK_OP_MSB + 1;
  localparam int NW  = core_io_port_pkg::OUT_WORDS;

  logic           CLK = 1'b0;
  logic           RST;
  logic           wr_en;
  logic [31:0]    din;
  logic [3:0]     wr_addr;
  logic           seq;
  logic [OPW-1:0] blk_op_in;
  logic           set_input_ready;
  logic           ready;
  logic           blk_start;
  logic           blk_seq;
  logic [OPW-1:0] blk_op;
  logic [3:0]     comp_rd_addr;
  logic [31:0]    comp_dout;
  logic           comp_done;
  logic           res_wr_en;
  logic [2:0]     res_addr;
  logic [31:0]    res_din;
  logic           res_last;
  logic           out_busy;
  logic [31:0]    core_dout;
  logic           core_dout_en;
  logic           core_dout_seq;
  logic           err;

  always #5 CLK = ~CLK;

  core_io_port #(.BLK_OP_W(OPW), .OUT_WORDS(NW)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .din(din), .wr_addr(wr_addr), .seq(seq),
    .blk_op_in(blk_op_in), .set_input_ready(set_input_ready), .ready(ready),
    .blk_start(blk_start), .blk_seq(blk_seq), .blk_op(blk_op),
    .comp_rd_addr(comp_rd_addr), .comp_dout(comp_dout), .comp_done(comp_done),
    .res_wr_en(res_wr_en), .res_addr(res_addr), .res_din(res_din), .res_last(res_last),
    .out_busy(out_busy), .core_dout(core_dout), .core_dout_en(core_dout_en),
    .core_dout_seq(core_dout_seq), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: slots form a ring; m_occ counts slots holding a block
  logic [31:0]    m_mem [2][16];
  logic [OPW-1:0] m_op  [2];
  logic [31:0]    m_res [NW];
  int             m_occ;
  logic           m_wr, m_rd;
`ifdef CORE_IO_CHECK_EN
  localparam logic ERR_ON_BAD = 1'b1;
`else
  localparam logic ERR_ON_BAD = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // fill slot s, optionally skipping one word; SIR on the last word or a cycle later,
  // optionally with comp_done in the SIR cycle
  task automatic fill(input logic s, input logic [OPW-1:0] op, input int skip,
                      input bit directed, input bit sir_last, input bit cd);
    int last;
    last = (skip == 15) ? 14 : 15;
    for (int a = 0; a < 16; a++) begin
      if (a != skip) begin
        wr_en   = 1'b1;
        seq     = s;
        wr_addr = 4'(a);
        din     = directed ? 32'(a) * 32'h11111111 : $urandom;
        m_mem[s][a] = din;
        if (a == last && sir_last) begin
          set_input_ready = 1'b1;
          blk_op_in       = op;
          comp_done       = cd;
        end
        tick();
        set_input_ready = 1'b0;
        comp_done       = 1'b0;
      end
    end
    wr_en = 1'b0;
    if (!sir_last) begin
      seq             = s;
      set_input_ready = 1'b1;
      blk_op_in       = op;
      comp_done       = cd;
      tick();
      set_input_ready = 1'b0;
      comp_done       = 1'b0;
    end
    m_op[s] = op;
    m_occ   = m_occ + 1 - int'(cd);
    m_wr    = ~m_wr;
    if (cd) m_rd = ~m_rd;
  endtask

  task automatic expect_start();
    check("blk_start", blk_start, 1);
    check("blk_seq", blk_seq, m_rd);
    check("blk_op", blk_op, m_op[m_rd]);
    tick();
    check("blk_start_pulse", blk_start, 0);
  endtask

  task automatic read_check(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15));
      comp_rd_addr = r;
      tick();
      check("comp_dout", comp_dout, m_mem[m_rd][r]);
    end
  endtask

  task automatic comp_finish();
    comp_done = 1'b1;
    tick();
    comp_done = 1'b0;
    m_occ--;
    m_rd = ~m_rd;
  endtask

  task automatic burst(input bit random_data, input int abort_at);
    for (int i = NW - 1; i >= 0; i--) begin
      res_wr_en = 1'b1;
      res_addr  = 3'(i);
      res_din   = random_data ? $urandom : 32'hA0 + 32'(i);
      m_res[i]  = res_din;
      tick();
    end
    res_wr_en = 1'b0;
    res_last  = 1'b1;
    tick();
    res_last = 1'b0;
    for (int i = 0; i < NW; i++) begin
      check("dout_en", core_dout_en, 1);
      check("dout", core_dout, m_res[i]);
      check("dout_seq", core_dout_seq, m_rd);
      check("out_busy", out_busy, 1);
      if (i == abort_at) return;
      tick();
    end
    check("dout_en_end", core_dout_en, 0);
    check("out_busy_end", out_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; wr_en = 1'b0; din = '0; wr_addr = '0; seq = 1'b0; blk_op_in = '0;
    set_input_ready = 1'b0; comp_rd_addr = '0; comp_done = 1'b0;
    res_wr_en = 1'b0; res_addr = '0; res_din = '0; res_last = 1'b0;
    m_occ = 0; m_wr = 1'b0; m_rd = 1'b0;
    repeat (2) tick();
    check("rst_ready", ready, 0);
    check("rst_blk_start", blk_start, 0);
    check("rst_blk_seq", blk_seq, 0);
    check("rst_blk_op", blk_op, 0);
    check("rst_dout_en", core_dout_en, 0);
    check("rst_dout", core_dout, 0);
    check("rst_dout_seq", core_dout_seq, 0);
    check("rst_out_busy", out_busy, 0);
    check("rst_err", err, 0);
    RST = 1'b0;
    tick();
    check("ready_after_rst", ready, 1);

    // directed first block into slot 0
    fill(m_wr, OPW'(2), -1, 1'b1, 1'b0, 1'b0);
    check("ready_one_full", ready, m_occ < 2);
    check("start_delay", blk_start, 0);
    tick();
    expect_start();
    comp_rd_addr = 4'd5;
    tick();
    check("comp_dout_5", comp_dout, 32'h55555555);
    read_check(3);

    // second slot waits FULL while first is busy
    fill(m_wr, OPW'($urandom_range(0, 7)), -1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("ready_both_full", ready, m_occ < 2);
      check("slot1_waits", blk_start, 0);
      tick();
    end
    comp_finish();
    check("ready_after_done", ready, m_occ < 2);
    check("no_start_same_cycle", blk_start, 0);
    tick();
    expect_start();
    read_check(3);
    check("err_clean_1", err, 0);

    // directed result burst
    burst(1'b0, -1);

    // comp_done and set_input_ready together, both orders of slots
    fill(m_wr, OPW'($urandom_range(0, 7)), -1, 1'b0, 1'b1, 1'b1);
    check("ready_simul_a", ready, m_occ < 2);
    tick();
    expect_start();
    read_check(2);
    fill(m_wr, OPW'($urandom_range(0, 7)), -1, 1'b0, 1'b1, 1'b1);
    check("ready_simul_b", ready, m_occ < 2);
    tick();
    expect_start();
    read_check(2);
    burst(1'b1, -1);
    check("err_clean_2", err, 0);

    // incomplete block: err depends on checking build
    fill(m_wr, OPW'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    check("ready_incomplete", ready, m_occ < 2);
    for (int i = 0; i < 3; i++) begin
      check("err_sticky", err, ERR_ON_BAD);
      check("no_start_busy", blk_start, 0);
      tick();
    end

    // reset in the middle of a burst, on word 3
    burst(1'b1, 3);
    RST = 1'b1;
    #1;
    check("abort_dout_en", core_dout_en, 0);
    check("abort_out_busy", out_busy, 0);
    check("abort_dout", core_dout, 0);
    check("abort_ready", ready, 0);
    check("abort_err", err, 0);
    check("abort_blk_seq", blk_seq, 0);
    tick();
    RST = 1'b0;
    m_occ = 0; m_wr = 1'b0; m_rd = 1'b0;
    tick();
    check("ready_after_abort", ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("slots_discarded", blk_start, 0);
      check("dout_idle", core_dout_en, 0);
      tick();
    end
    fill(m_wr, OPW'($urandom_range(0, 7)), -1, 1'b0, 1'b1, 1'b0);
    check("ready_refill", ready, m_occ < 2);
    tick();
    expect_start();
    read_check(2);
    check("err_final", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
